// File: rtl/pa_spsram_ctrl_param_if.sv
// Request / read-return bundle for the parametrised single-port SRAM controller.
`timescale 1ns/1ps
interface pa_spsram_ctrl_param_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 32
) ();
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [WE_WIDTH-1:0]   req_wmask;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  init_done;

  modport master (
    output req_vld, req_wr, req_addr,
    output req_wdata, req_wmask,
    input  req_rdy, rd_vld, rd_data,
    input  init_done
  );

  modport slave (
    input  req_vld, req_wr, req_addr,
    input  req_wdata, req_wmask,
    output req_rdy, rd_vld, rd_data,
    output init_done
  );
endinterface

// File: rtl/pa_spsram_ctrl_param.sv
// Parametrised single-port SRAM controller: masked writes, 1/2-cycle reads,
// held read data and a post-reset initialisation sweep.
`timescale 1ns/1ps
module pa_spsram_ctrl_param #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 32,
  parameter int OUT_REG    = 0,
  parameter int INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic CLK,
  input logic RST,
  pa_spsram_ctrl_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int GRAN  = DATA_WIDTH / WE_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_idle;
  logic [ADDR_WIDTH-1:0] r_cnt;

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_rd;
  logic                  w_init_we;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_bmask;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_vld1;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  w_vld_o;
  logic [DATA_WIDTH-1:0] w_dat_o;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_idle = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        if (r_cnt == '1)
          w_next = ST_IDLE;
      end
      ST_IDLE: begin
        w_idle = 1'b1;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // Outputs are forced to their reset values while RST is high.
  assign w_ready       = w_idle & ~RST;
  assign bus.req_rdy   = w_ready;
  assign bus.init_done = w_ready;

  assign w_acc     = bus.req_vld & w_ready;
  assign w_rd      = w_acc & ~bus.req_wr;
  assign w_init_we = (r_state == ST_INIT) & ~RST;
  assign w_we      = w_init_we | (w_acc & bus.req_wr);
  assign w_waddr   = w_init_we ? r_cnt : bus.req_addr;
  assign w_wdata   = w_init_we ? INIT_VALUE : bus.req_wdata;

  for (genvar g = 0; g < WE_WIDTH; g++) begin : g_mask
    assign w_bmask[g*GRAN +: GRAN] =
      {GRAN{w_init_we | bus.req_wmask[g]}};
  end

  always_ff @(posedge CLK) begin
    if (w_we)
      r_mem[w_waddr] <= (r_mem[w_waddr] & ~w_bmask)
                      | (w_wdata & w_bmask);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld1 <= 1'b0;
      r_d1   <= '0;
    end else begin
      r_vld1 <= w_rd;
      if (w_rd)
        r_d1 <= r_mem[bus.req_addr];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  r_vld2;
    logic [DATA_WIDTH-1:0] r_d2;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_vld2 <= 1'b0;
        r_d2   <= '0;
      end else begin
        r_vld2 <= r_vld1;
        if (r_vld1)
          r_d2 <= r_d1;
      end
    end

    assign w_vld_o = r_vld2;
    assign w_dat_o = r_d2;
  end else begin : g_noreg
    assign w_vld_o = r_vld1;
    assign w_dat_o = r_d1;
  end

  assign bus.rd_vld  = w_vld_o & ~RST;
  assign bus.rd_data = RST ? '0 : w_dat_o;
endmodule

// File: tb/tb_pa_spsram_ctrl_param.sv
// Randomised bench for pa_spsram_ctrl_param: three configurations share one
// stimulus stream and are each compared every cycle to a word-level model.
`timescale 1ns/1ps
module tb_pa_spsram_ctrl_param;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int WW    = 32;
  localparam int DEPTH = 1 << AW;
  localparam int N     = 3;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          s_vld;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [WW-1:0] s_wmask;

  pa_spsram_ctrl_param_if #(AW, DW, WW) bus0 ();
  pa_spsram_ctrl_param_if #(AW, DW, WW) bus1 ();
  pa_spsram_ctrl_param_if #(AW, DW, WW) bus2 ();

  assign bus0.req_vld   = s_vld;
  assign bus0.req_wr    = s_wr;
  assign bus0.req_addr  = s_addr;
  assign bus0.req_wdata = s_wdata;
  assign bus0.req_wmask = s_wmask;
  assign bus1.req_vld   = s_vld;
  assign bus1.req_wr    = s_wr;
  assign bus1.req_addr  = s_addr;
  assign bus1.req_wdata = s_wdata;
  assign bus1.req_wmask = s_wmask;
  assign bus2.req_vld   = s_vld;
  assign bus2.req_wr    = s_wr;
  assign bus2.req_addr  = s_addr;
  assign bus2.req_wdata = s_wdata;
  assign bus2.req_wmask = s_wmask;

  logic          o_rdy  [N];
  logic          o_vld  [N];
  logic          o_done [N];
  logic [DW-1:0] o_dat  [N];

  assign o_rdy[0]  = bus0.req_rdy;
  assign o_vld[0]  = bus0.rd_vld;
  assign o_done[0] = bus0.init_done;
  assign o_dat[0]  = bus0.rd_data;
  assign o_rdy[1]  = bus1.req_rdy;
  assign o_vld[1]  = bus1.rd_vld;
  assign o_done[1] = bus1.init_done;
  assign o_dat[1]  = bus1.rd_data;
  assign o_rdy[2]  = bus2.req_rdy;
  assign o_vld[2]  = bus2.rd_vld;
  assign o_done[2] = bus2.init_done;
  assign o_dat[2]  = bus2.rd_data;

  pa_spsram_ctrl_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .OUT_REG(0), .INIT_EN(1), .INIT_VALUE(32'h0)
  ) u_dut0 (.CLK(CLK), .RST(RST), .bus(bus0));

  pa_spsram_ctrl_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .OUT_REG(1), .INIT_EN(1), .INIT_VALUE(32'hDEADBEEF)
  ) u_dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  pa_spsram_ctrl_param #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
    .OUT_REG(0), .INIT_EN(0), .INIT_VALUE(32'h0)
  ) u_dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  function automatic int lat(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic bit ien(int k);
    return (k != 2);
  endfunction

  function automatic logic [DW-1:0] ival(int k);
    return (k == 1) ? 32'hDEADBEEF : 32'h0;
  endfunction

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            kn;
  } exp_t;

  int            cyc;
  int            since;
  int            n_chk;
  int            n_pass;
  logic [DW-1:0] mem   [N][DEPTH];
  bit            known [N][DEPTH];
  exp_t          q     [N][$];
  logic [DW-1:0] last  [N];
  bit            lk    [N];

  task automatic check(string tag, logic [DW-1:0] got,
                       logic [DW-1:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // A configuration is usable once reset is low and its sweep has had
  // DEPTH clean cycles (or immediately when it has no sweep).
  function automatic bit exp_rdy(int k);
    return !RST && (!ien(k) || since >= DEPTH);
  endfunction

  task automatic model_edge();
    cyc++;
    if (RST) begin
      since = 0;
      for (int k = 0; k < N; k++) q[k].delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (s_vld && exp_rdy(k)) begin
          if (s_wr) begin
            mem[k][s_addr] = (mem[k][s_addr] & ~s_wmask)
                           | (s_wdata & s_wmask);
            if (s_wmask == '1) known[k][s_addr] = 1'b1;
          end else begin
            exp_t e;
            e.due  = cyc + lat(k) - 1;
            e.data = mem[k][s_addr];
            e.kn   = known[k][s_addr];
            q[k].push_back(e);
          end
        end
      end
      since++;
      if (since == DEPTH) begin
        for (int k = 0; k < N; k++) begin
          if (ien(k)) begin
            for (int a = 0; a < DEPTH; a++) begin
              mem[k][a]   = ival(k);
              known[k][a] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < N; k++) begin
      bit   er;
      bit   ev;
      exp_t e;
      er = exp_rdy(k);
      ev = 1'b0;
      check($sformatf("req_rdy[%0d]", k), o_rdy[k], er);
      check($sformatf("init_done[%0d]", k), o_done[k], er);
      if (q[k].size() != 0 && q[k][0].due == cyc) begin
        e = q[k].pop_front();
        if (!RST) begin
          ev      = 1'b1;
          last[k] = e.data;
          lk[k]   = e.kn;
        end
      end
      if (RST) begin
        last[k] = '0;
        lk[k]   = 1'b1;
      end
      check($sformatf("rd_vld[%0d]", k), o_vld[k], ev);
      if (lk[k])
        check($sformatf("rd_data[%0d]", k), o_dat[k], last[k]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic drive(bit v, bit w, logic [AW-1:0] a,
                       logic [DW-1:0] d, logic [WW-1:0] m);
    s_vld   = v;
    s_wr    = w;
    s_addr  = a;
    s_wdata = d;
    s_wmask = m;
    tick();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [AW-1:0] tbl(int i);
    case (i)
      0: return 11'h000;
      1: return 11'h001;
      2: return 11'h002;
      3: return 11'h010;
      4: return 11'h020;
      5: return 11'h100;
      6: return 11'h3FF;
      7: return 11'h400;
      8: return 11'h7FE;
      default: return 11'h7FF;
    endcase
  endfunction

  task automatic rand_ops(int n);
    for (int i = 0; i < n; i++) begin
      logic [WW-1:0] m;
      case ($urandom_range(0, 3))
        0: m = '0;
        1: m = '1;
        2: m = 32'h0000FFFF;
        default: m = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            tbl($urandom_range(0, 9)), $urandom, m);
    end
  endtask

  initial begin
    cyc    = 0;
    since  = 0;
    n_chk  = 0;
    n_pass = 0;
    for (int k = 0; k < N; k++) begin
      lk[k]   = 1'b0;
      last[k] = '0;
      for (int a = 0; a < DEPTH; a++) known[k][a] = 1'b0;
    end
    RST     = 1'b1;
    s_vld   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    repeat (3) tick();
    RST = 1'b0;

    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, tbl(i), $urandom, '1);
    rand_ops(90);

    RST = 1'b1;
    s_vld = 1'b0;
    tick();
    RST = 1'b0;
    rand_ops(DEPTH - 10);
    idle(20);

    drive(1'b1, 1'b0, 11'h000, '0, '0);
    drive(1'b1, 1'b0, 11'h3FF, '0, '0);
    drive(1'b1, 1'b0, 11'h7FF, '0, '0);
    idle(3);

    drive(1'b1, 1'b1, 11'h010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drive(1'b1, 1'b1, 11'h010, 32'h12345678, 32'h0000FFFF);
    drive(1'b1, 1'b0, 11'h010, '0, '0);
    idle(2);
    drive(1'b1, 1'b1, 11'h010, $urandom, 32'h0);
    drive(1'b1, 1'b0, 11'h010, '0, '0);
    idle(2);

    drive(1'b1, 1'b1, 11'h020, 32'h5, '1);
    drive(1'b1, 1'b0, 11'h020, '0, '0);
    drive(1'b1, 1'b0, 11'h010, '0, '0);
    drive(1'b1, 1'b0, 11'h020, '0, '0);
    drive(1'b1, 1'b0, 11'h3FF, '0, '0);
    drive(1'b1, 1'b0, 11'h000, '0, '0);
    idle(4);

    rand_ops(1500);

    drive(1'b1, 1'b0, 11'h020, '0, '0);
    s_vld = 1'b0;
    RST   = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    idle(DEPTH + 5);
    drive(1'b1, 1'b0, 11'h020, '0, '0);
    drive(1'b1, 1'b0, 11'h7FF, '0, '0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pa_spsram_ctrl_param.md
Name: pa_spsram_ctrl_param

Overview:
- Parametrised single-port SRAM controller with a behavioural storage array; successor to the fixed 2048x32 single-port wrapper.
- Depth, width and write-mask granularity are configurable, plus an optional output register stage.
- Adds a valid/ready request handshake, a read-valid return strobe, read-data hold, and a post-reset memory initialisation sweep.
- Used by LSU/IFU-side local buffers that need known-clean contents after reset.

Parameters:
- ADDR_WIDTH, 11, address bits; DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 32, data word width.
- WE_WIDTH, 32, write-mask bits. DATA_WIDTH must be an integer multiple of WE_WIDTH. Each mask bit covers DATA_WIDTH/WE_WIDTH data bits.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- INIT_EN, 1, 1 = sweep INIT_VALUE into every entry after reset; 0 = no sweep.
- INIT_VALUE, 0, DATA_WIDTH-bit word written during the sweep.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  controller can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  WE_WIDTH  active-high write mask.
- rd_vld  out  1  one-cycle strobe: rd_data is new this cycle.
- rd_data  out  DATA_WIDTH  read data, held until the next read return.
- init_done  out  1  high once the array is usable; stays high until reset.

Behaviour:
- Clocking and reset: one clock CLK. Reset RST is synchronous and active-high.
- Output reset values while RST=1:
  - req_rdy=0, rd_vld=0, rd_data=0, init_done=0.
  - Internal pipeline valids are cleared; the init counter is set to 0.
  - Array contents are not reset by RST.
- State machine, two states: INIT and IDLE.
- First cycle after RST falls:
  - INIT_EN=1: enter INIT.
  - INIT_EN=0: enter IDLE directly; init_done=1 and req_rdy=1 from that first cycle.
- INIT state:
  - Each cycle, write INIT_VALUE to array[cnt] with full mask, then cnt+1.
  - cnt is ADDR_WIDTH bits wide. Terminal detection compares cnt to all-ones; there is no wrap past DEPTH-1.
  - After the write at DEPTH-1, go to IDLE. init_done and req_rdy rise in the following cycle.
  - The sweep takes exactly DEPTH cycles.
  - req_rdy=0 throughout INIT; req_vld is ignored and requests are not queued.
- IDLE state:
  - req_rdy=1 every cycle; one operation per cycle, with no stall.
  - Acceptance is req_vld & req_rdy, sampled on the rising edge.
- Write (accepted with req_wr=1):
  - At the accept edge, update array bits whose mask bit is set; all other bits keep their value.
  - A write with mask all-zero makes no array change.
  - Writes produce no rd_vld.
- Read (accepted with req_wr=0, at edge N):
  - OUT_REG=0: array data is registered at edge N; rd_vld=1 and rd_data valid in cycle N+1.
  - OUT_REG=1: one more stage; rd_vld and rd_data appear in cycle N+2.
  - rd_vld is high for exactly one cycle per accepted read.
  - rd_data holds its last returned value until the next read return.
- Write then read of the same address in consecutive cycles returns the newly written data; the write has already committed.
- Back-to-back reads: one result per cycle, in order, with no bubbles.
- Reset asserted mid-INIT: the sweep restarts from address 0 and takes a full DEPTH cycles again.
- Reset asserted with reads in flight: their rd_vld is suppressed and never appears; rd_data=0.
- Reading before init_done is impossible, because req_rdy=0.
- req_wdata and req_wmask are don't-care on reads; req_wr, req_addr, req_wdata and req_wmask are don't-care when req_vld=0.

Test Plan:
- Init sweep, defaults: release RST → init_done=0 and req_rdy=0 for exactly 2048 cycles, then 1. Reading 0x000, 0x3FF and 0x7FF each gives rd_data=0x00000000 with rd_vld 1 cycle after accept.
- Masked write: write 0xFFFFFFFF with mask 0xFFFFFFFF to 0x010, then 0x12345678 with mask 0x0000FFFF, then read 0x010 → 0xFFFF5678. A mask-0 write followed by a read → unchanged value.
- Back-to-back: write 0x5 to 0x020 in cycle N, read 0x020 in N+1 → rd_vld in N+2 with data 0x5. Four consecutive reads → four consecutive rd_vld pulses, in order. rd_data holds after the last one.
- OUT_REG=1, INIT_VALUE=0xDEADBEEF: read accepted at edge N → rd_vld only in cycle N+2 with 0xDEADBEEF. rd_vld is 0 in N+1.
- Reset mid-operation: assert RST at init cnt=100 → init_done stays 0 for 2048 cycles after release. Assert RST 1 cycle after a read accept → no rd_vld is ever seen; rd_data=0.
- INIT_EN=0: init_done=1 in the first cycle after reset. req_vld driven during INIT (INIT_EN=1) is never accepted and causes no array change, checked by later reads returning INIT_VALUE.
